// File: rtl/stream_accumulator_pkg.sv
// Shared encodings for the multiplier/accumulator datapath: FSM states, tuser bit indices, widths.
package stream_accumulator_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } acc_state_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam int TUSER_SAT    = 0;
    localparam int TUSER_FORCED = 1;
    localparam int TUSER_W      = 2;

    // One guard bit beyond the frame-length growth keeps the sign for any MAX_LEN-sample sum.
    function automatic int acc_width(input int width, input int max_len);
        return width + $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/stream_accumulator_if.sv
// Sample-in / result-out stream bundle; slave is the accumulator's view, master the environment's.
interface stream_accumulator_if #(
    parameter int WIDTH = 16
) ();

    logic                                        tvalid_slave;
    logic [WIDTH-1:0]                            tdata_slave;
    logic                                        tlast_slave;
    logic                                        tready_slave;
    logic                                        tvalid_master;
    logic [WIDTH-1:0]                            tdata_master;
    logic [stream_accumulator_pkg::TUSER_W-1:0]  tuser_master;
    logic                                        tready_master;

    modport slave (
        input  tvalid_slave, tdata_slave, tlast_slave, tready_master,
        output tready_slave, tvalid_master, tdata_master, tuser_master
    );

    modport master (
        output tvalid_slave, tdata_slave, tlast_slave, tready_master,
        input  tready_slave, tvalid_master, tdata_master, tuser_master
    );

endinterface

// File: rtl/stream_accumulator_round_saturate.sv
// Narrow a signed wide value: round-half-up arithmetic shift by SHIFT, then clamp to OUT_W bits.
// Purely combinational; sat is high whenever the clamp changed the value.
module round_saturate #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    localparam logic signed [IN_W:0] MAX_V = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Extra top bit so adding the rounding constant can never wrap.
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rounded;

    assign ext = {acc[IN_W-1], acc};

    generate
        if (SHIFT == 0) begin : g_no_round
            assign rounded = ext;
        end else begin : g_round
            localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
            assign rounded = (ext + HALF) >>> SHIFT;
        end
    endgenerate

    always_comb begin
        sat    = 1'b0;
        result = rounded[OUT_W-1:0];
        if (rounded > MAX_V) begin
            sat    = 1'b1;
            result = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (rounded < MIN_V) begin
            sat    = 1'b1;
            result = {1'b1, {(OUT_W - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/stream_accumulator.sv
// Sums a frame of signed samples and emits one rounded/saturated result per frame.
// Latency: result valid the cycle after the closing sample is accepted.
// Backpressure: input stalls (tready_slave=0) from frame close until the result is taken.
module stream_accumulator
    import stream_accumulator_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 8,
    parameter int SHIFT   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    stream_accumulator_if.slave  bus
);

    localparam int              ACC_W    = acc_width(WIDTH, MAX_LEN);
    localparam int              CNT_W    = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    acc_state_e              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0]        count;
    logic                    in_rdy;
    logic                    in_xfer;
    logic                    frame_close;
    logic signed [WIDTH-1:0] rs_result;
    logic                    rs_sat;
    logic                    out_vld;
    logic [WIDTH-1:0]        out_dat;
    logic [TUSER_W-1:0]      out_user;

    // Ready depends only on registered state and reset, never on tready_master.
    assign in_rdy      = (state == ACCUM) & reset_n;
    assign in_xfer     = bus.tvalid_slave & in_rdy;
    assign frame_close = bus.tlast_slave | (count == LAST_IDX);
    assign sample_ext  = {{(ACC_W - WIDTH){bus.tdata_slave[WIDTH-1]}}, bus.tdata_slave};
    assign acc_next    = acc + sample_ext;

    round_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (WIDTH),
        .SHIFT (SHIFT)
    ) u_round_saturate (
        .acc    (acc_next),
        .result (rs_result),
        .sat    (rs_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_user <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_xfer) begin
                        if (frame_close) begin
                            out_dat                <= rs_result;
                            out_user[TUSER_SAT]    <= rs_sat;
                            out_user[TUSER_FORCED] <= ~bus.tlast_slave;
                            out_vld                <= 1'b1;
                            acc                    <= '0;
                            count                  <= '0;
                            state                  <= OUTPUT;
                        end else begin
                            acc   <= acc_next;
                            count <= count + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (bus.tready_master) begin
                        out_vld <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.tready_slave  = in_rdy;
    assign bus.tvalid_master = out_vld;
    assign bus.tdata_master  = out_dat;
    assign bus.tuser_master  = out_user;

endmodule

// File: tb/tb_stream_accumulator.sv
// Drives SHIFT=0 and SHIFT=2 accumulators in lockstep from one directed stimulus stream.
module tb_stream_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_vld;
    logic [15:0] in_dat;
    logic        in_last;
    logic        out_rdy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_accumulator_if #(.WIDTH(16)) if0 ();
    stream_accumulator_if #(.WIDTH(16)) if2 ();

    assign if0.tvalid_slave  = in_vld;
    assign if0.tdata_slave   = in_dat;
    assign if0.tlast_slave   = in_last;
    assign if0.tready_master = out_rdy;
    assign if2.tvalid_slave  = in_vld;
    assign if2.tdata_slave   = in_dat;
    assign if2.tlast_slave   = in_last;
    assign if2.tready_master = out_rdy;

    stream_accumulator #(.WIDTH(16), .MAX_LEN(8), .SHIFT(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0)
    );

    stream_accumulator #(.WIDTH(16), .MAX_LEN(8), .SHIFT(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if2)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Frame result from the sum: optional round-half-up shift, then clamp to 16-bit signed.
    function automatic int frame_result(input int sum, input int sh, output int sat);
        int r;
        r   = sum;
        sat = 0;
        if (sh > 0) r = (sum + (1 << (sh - 1))) >>> sh;
        if (r > 32767) begin
            r   = 32767;
            sat = 1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1;
        end
        return r;
    endfunction

    // Model: collect accepted samples; a frame ends on tlast or the 8th sample; one result
    // is then outstanding and blocks input until it is taken.
    int samples[$];
    bit pending = 0;
    int exp_d0, exp_u0, exp_d2, exp_u2;

    always @(negedge clk) begin
        if (!reset_n) begin
            samples.delete();
            pending = 0;
            check("rst_vld0", int'(if0.tvalid_master), 0);
            check("rst_dat0", int'(if0.tdata_master), 0);
            check("rst_usr0", int'(if0.tuser_master), 0);
            check("rst_rdy0", int'(if0.tready_slave), 0);
            check("rst_vld2", int'(if2.tvalid_master), 0);
            check("rst_rdy2", int'(if2.tready_slave), 0);
        end else begin
            check("rdy0", int'(if0.tready_slave), int'(!pending));
            check("rdy2", int'(if2.tready_slave), int'(!pending));
            check("vld0", int'(if0.tvalid_master), int'(pending));
            check("vld2", int'(if2.tvalid_master), int'(pending));
            if (pending) begin
                check("dat0", int'($signed(if0.tdata_master)), exp_d0);
                check("usr0", int'(if0.tuser_master), exp_u0);
                check("dat2", int'($signed(if2.tdata_master)), exp_d2);
                check("usr2", int'(if2.tuser_master), exp_u2);
                if (out_rdy) pending = 0;
            end else if (in_vld) begin
                samples.push_back(int'($signed(in_dat)));
                if (in_last || samples.size() == 8) begin
                    int sum, s0, s2;
                    sum = 0;
                    foreach (samples[i]) sum += samples[i];
                    exp_d0  = frame_result(sum, 0, s0);
                    exp_d2  = frame_result(sum, 2, s2);
                    exp_u0  = (in_last ? 0 : 2) + s0;
                    exp_u2  = (in_last ? 0 : 2) + s2;
                    pending = 1;
                    samples.delete();
                end
            end
        end
    end

    task automatic send(input int d, input bit last);
        int n;
        n       = 0;
        in_vld  = 1'b1;
        in_dat  = 16'(d);
        in_last = last;
        @(negedge clk);
        while (!if0.tready_slave && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    // Wait for the result, pin it against hand-computed values, then accept it.
    task automatic take(input string nm, input int d0, input int u0, input int d2, input int u2);
        int n;
        n = 0;
        @(negedge clk);
        while (!if0.tvalid_master && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_vld"}, int'(if0.tvalid_master), 1);
        check({nm, "_d0"}, int'($signed(if0.tdata_master)), d0);
        check({nm, "_u0"}, int'(if0.tuser_master), u0);
        check({nm, "_d2"}, int'($signed(if2.tdata_master)), d2);
        check({nm, "_u2"}, int'(if2.tuser_master), u2);
        @(posedge clk);
        #1 out_rdy = 1'b1;
        @(posedge clk);
        #1 out_rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_vld  = 1'b0;
        in_dat  = '0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        send(100, 0); send(-30, 0); send(5, 1);
        take("f_mix", 75, 0, 19, 0);

        send(32767, 0); send(32767, 1);
        take("f_pos_sat", 32767, 1, 16384, 0);

        send(-32768, 0); send(-1, 1);
        take("f_neg_sat", -32768, 1, -8192, 0);

        for (int i = 0; i < 8; i++) send(1, 0);
        take("f_forced", 8, 2, 2, 2);
        send(3, 1);
        take("f_ninth", 3, 0, 1, 0);

        send(5, 1);  take("f_5", 5, 0, 1, 0);
        send(6, 1);  take("f_6", 6, 0, 2, 0);
        send(-6, 1); take("f_m6", -6, 0, -1, 0);

        // Result held while downstream stalls; the waiting sample must not be taken.
        send(9, 1);
        in_vld  = 1'b1;
        in_dat  = 16'd4;
        in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_vld", int'(if0.tvalid_master), 1);
            check("stall_dat", int'($signed(if0.tdata_master)), 9);
            check("stall_rdy", int'(if0.tready_slave), 0);
        end
        @(posedge clk);
        #1 out_rdy = 1'b1;
        @(posedge clk);
        #1 out_rdy = 1'b0;
        send(4, 1);
        take("f_after_stall", 4, 0, 1, 0);

        // Reset mid-frame discards the partial sum.
        send(10, 0); send(20, 0); send(30, 0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        send(7, 1);
        take("f_post_rst", 7, 0, 2, 0);

        // Reset during a pending result drops tvalid without a clock edge.
        send(1, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_vld0", int'(if0.tvalid_master), 0);
        check("async_vld2", int'(if2.tvalid_master), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
